// File: rtl/tpu_ctrl_pkg.sv
// rtl/tpu_ctrl_pkg.sv - shared state encoding and array constants for the feed sequencer
// Purpose: state enum and fixed array/serial-number constants used by feed_seq_ctrl.
// Ports: none (package).
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_t;

    localparam int              ARRAY_SIZE = 32;
    localparam int              SERIAL_W   = 7;
    // Last serial number of a sweep; the selector decodes IDLE_NUM as the all-zero row.
    localparam logic [SERIAL_W-1:0] SERIAL_MAX = 7'd126;
    localparam logic [SERIAL_W-1:0] IDLE_NUM   = 7'd127;

endpackage

// File: rtl/feed_seq_ctrl_hold_counter.sv
// rtl/feed_seq_ctrl_hold_counter.sv - up-counter with clear, enable and terminal-count flag
// Purpose: counts up while en is high, clr has priority, saturates at TERM so it never wraps.
// Ports:
//   clk, srstn : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero
//   en         : count enable (driven with !stall by the sequencer)
//   count      : current count
//   tc         : high while count == TERM
module hold_counter #(
    parameter int W    = 7,
    parameter int TERM = 126
) (
    input  logic         clk,
    input  logic         srstn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(TERM));

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/feed_seq_ctrl.sv
// rtl/feed_seq_ctrl.sv - serial-number sequencer feeding the systolic-array SRAM address selector
// Purpose: per tile, sweeps 0..SERIAL_MAX (one step per un-stalled cycle), drains for
//          DRAIN_CYCLES, pulses tile_done; pulses done after the last tile.
// Ports:
//   clk, srstn      : clock, asynchronous active-low reset
//   start           : run request, only honoured in IDLE
//   num_tiles       : tile count, latched on an accepted start
//   stall           : freezes serial and drain counters
//   addr_serial_num : serial number to the selector (IDLE_NUM when not feeding)
//   feed_valid      : addr_serial_num is a live feed step
//   tile_idx        : tile currently feeding or draining
//   busy            : high in FEED, DRAIN and DONE
//   tile_done       : one-cycle pulse in the last drain cycle of a tile
//   done            : one-cycle pulse after the last tile
module feed_seq_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 34,
    parameter int TILE_W       = 4
) (
    input  logic                clk,
    input  logic                srstn,
    input  logic                start,
    input  logic [TILE_W-1:0]   num_tiles,
    input  logic                stall,
    output logic [SERIAL_W-1:0] addr_serial_num,
    output logic                feed_valid,
    output logic [TILE_W-1:0]   tile_idx,
    output logic                busy,
    output logic                tile_done,
    output logic                done
);

    localparam int DRAIN_W = 8;
    // tile_done is registered, so it is raised one edge before the drain counter's last value.
    localparam int DRAIN_PRE = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 2 : 0;

    feed_state_t          state;
    logic [TILE_W-1:0]    tiles_lat;
    logic [SERIAL_W-1:0]  ser_cnt;
    logic                 ser_tc;
    logic [DRAIN_W-1:0]   drn_cnt;
    logic                 drn_tc;

    hold_counter #(.W(SERIAL_W), .TERM(int'(SERIAL_MAX))) u_serial_cnt (
        .clk   (clk),
        .srstn (srstn),
        .clr   (state != ST_FEED),
        .en    ((state == ST_FEED) && !stall),
        .count (ser_cnt),
        .tc    (ser_tc)
    );

    hold_counter #(.W(DRAIN_W), .TERM(DRAIN_CYCLES - 1)) u_drain_cnt (
        .clk   (clk),
        .srstn (srstn),
        .clr   (state != ST_DRAIN),
        .en    ((state == ST_DRAIN) && !stall),
        .count (drn_cnt),
        .tc    (drn_tc)
    );

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state           <= ST_IDLE;
            tiles_lat       <= '0;
            addr_serial_num <= IDLE_NUM;
            feed_valid      <= 1'b0;
            tile_idx        <= '0;
            busy            <= 1'b0;
            tile_done       <= 1'b0;
            done            <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        tile_idx <= '0;
                        if (num_tiles != '0) begin
                            tiles_lat       <= num_tiles;
                            state           <= ST_FEED;
                            addr_serial_num <= '0;
                            feed_valid      <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_FEED: begin
                    if (stall) begin
                        feed_valid <= 1'b0;
                    end else if (ser_tc) begin
                        state           <= ST_DRAIN;
                        addr_serial_num <= IDLE_NUM;
                        feed_valid      <= 1'b0;
                        // A one-cycle drain window is also its last cycle.
                        if (DRAIN_CYCLES == 1) tile_done <= 1'b1;
                    end else begin
                        addr_serial_num <= ser_cnt + SERIAL_W'(1);
                        feed_valid      <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        if (drn_tc) begin
                            if (tile_idx == tiles_lat - TILE_W'(1)) begin
                                state <= ST_DONE;
                            end else begin
                                tile_idx        <= tile_idx + TILE_W'(1);
                                state           <= ST_FEED;
                                addr_serial_num <= '0;
                                feed_valid      <= 1'b1;
                            end
                        end else if (drn_cnt == DRAIN_W'(DRAIN_PRE)) begin
                            tile_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // First DONE cycle raises done; second returns to IDLE.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        busy     <= 1'b0;
                        tile_idx <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_feed_seq_ctrl.sv
// tb/tb_feed_seq_ctrl.sv - directed self-checking bench for feed_seq_ctrl
module tb_feed_seq_ctrl;

    logic       clk;
    logic       srstn;
    logic       start;
    logic [3:0] num_tiles;
    logic       stall;
    logic [6:0] addr_serial_num;
    logic       feed_valid;
    logic [3:0] tile_idx;
    logic       busy;
    logic       tile_done;
    logic       done;

    int checks = 0;
    int errors = 0;

    int done_k, fv_cnt, td_cnt, seq_bad, idle_cnt, held_cnt;
    int td_k[3];
    int td_idx[3];
    logic [31:0] first_addr, first_fv, first_busy, post_busy, post_done;

    feed_seq_ctrl #(.DRAIN_CYCLES(34), .TILE_W(4)) dut (
        .clk             (clk),
        .srstn           (srstn),
        .start           (start),
        .num_tiles       (num_tiles),
        .stall           (stall),
        .addr_serial_num (addr_serial_num),
        .feed_valid      (feed_valid),
        .tile_idx        (tile_idx),
        .busy            (busy),
        .tile_done       (tile_done),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called one cycle after the start edge (k=0). Observes every cycle until done,
    // injecting a 5-cycle feed stall at stall_addr, a 3-cycle stall at drain_k,
    // a stray start at start_k and a num_tiles change at chg_k.
    task automatic run(input int max_k, input int stall_addr, input int drain_k,
                       input int start_k, input int chg_k);
        int exp_a;
        int stall_rem;
        exp_a = 0; stall_rem = 0;
        done_k = -1; fv_cnt = 0; td_cnt = 0; seq_bad = 0; idle_cnt = 0; held_cnt = 0;
        for (int i = 0; i < 3; i++) begin td_k[i] = -1; td_idx[i] = -1; end
        for (int k = 0; k <= max_k && done_k < 0; k++) begin
            if (k == 0) begin
                first_addr = 32'(addr_serial_num);
                first_fv   = 32'(feed_valid);
                first_busy = 32'(busy);
            end
            if (feed_valid) begin
                fv_cnt++;
                if (addr_serial_num !== 7'(exp_a)) seq_bad++;
                exp_a = (exp_a == 126) ? 0 : exp_a + 1;
            end
            if (busy && addr_serial_num == 7'd127) idle_cnt++;
            if (stall_addr >= 0 && !feed_valid && busy && 32'(addr_serial_num) == stall_addr)
                held_cnt++;
            if (tile_done) begin
                if (td_cnt < 3) begin td_k[td_cnt] = k; td_idx[td_cnt] = int'(tile_idx); end
                td_cnt++;
            end
            if (done) done_k = k;
            if (stall_addr >= 0 && feed_valid && 32'(addr_serial_num) == stall_addr) stall_rem = 5;
            if (k == drain_k) stall_rem = 3;
            stall = (stall_rem > 0);
            if (stall_rem > 0) stall_rem--;
            start = (k == start_k);
            if (k == chg_k) num_tiles = 4'd1;
            if (done_k < 0) step();
        end
        stall = 1'b0;
        start = 1'b0;
        step();
        post_busy = 32'(busy);
        post_done = 32'(done);
    endtask

    initial begin
        int guard;
        int bad_pulses;
        srstn = 1'b0; start = 1'b0; stall = 1'b0; num_tiles = 4'd0;
        step(); step();
        chk("rst_addr", 32'(addr_serial_num), 127);
        chk("rst_fv", 32'(feed_valid), 0);
        chk("rst_tile_idx", 32'(tile_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tile_done", 32'(tile_done), 0);
        chk("rst_done", 32'(done), 0);
        srstn = 1'b1;
        step();

        // Single tile, no stall.
        start = 1'b1; num_tiles = 4'd1;
        step();
        run(400, -1, -1, -1, -1);
        chk("t1_first_addr", first_addr, 0);
        chk("t1_first_fv", first_fv, 1);
        chk("t1_first_busy", first_busy, 1);
        chk("t1_done_k", done_k, 162);
        chk("t1_fv_cnt", fv_cnt, 127);
        chk("t1_seq_bad", seq_bad, 0);
        chk("t1_td_cnt", td_cnt, 1);
        chk("t1_td_k", td_k[0], 160);
        chk("t1_td_idx", td_idx[0], 0);
        chk("t1_idle_cnt", idle_cnt, 36);
        chk("t1_post_busy", post_busy, 0);
        chk("t1_post_done", post_done, 0);

        // Three tiles with a stray start mid-feed and num_tiles changed mid-run.
        step();
        start = 1'b1; num_tiles = 4'd3;
        step();
        run(800, -1, -1, 60, 70);
        chk("t3_done_k", done_k, 484);
        chk("t3_fv_cnt", fv_cnt, 381);
        chk("t3_seq_bad", seq_bad, 0);
        chk("t3_td_cnt", td_cnt, 3);
        chk("t3_td_k0", td_k[0], 160);
        chk("t3_td_k1", td_k[1], 321);
        chk("t3_td_k2", td_k[2], 482);
        chk("t3_td_idx0", td_idx[0], 0);
        chk("t3_td_idx1", td_idx[1], 1);
        chk("t3_td_idx2", td_idx[2], 2);
        chk("t3_idle_cnt", idle_cnt, 104);
        chk("t3_post_busy", post_busy, 0);

        // Single tile with a 5-cycle stall at serial 40 and a 3-cycle stall in drain.
        step();
        start = 1'b1; num_tiles = 4'd1;
        step();
        run(400, 40, 140, -1, -1);
        chk("st_done_k", done_k, 170);
        chk("st_fv_cnt", fv_cnt, 127);
        chk("st_seq_bad", seq_bad, 0);
        chk("st_held_cnt", held_cnt, 5);
        chk("st_td_k", td_k[0], 168);
        chk("st_idle_cnt", idle_cnt, 39);
        chk("st_td_cnt", td_cnt, 1);

        // Zero tiles: straight to DONE.
        step();
        start = 1'b1; num_tiles = 4'd0;
        step();
        run(50, -1, -1, -1, -1);
        chk("z_first_busy", first_busy, 1);
        chk("z_done_k", done_k, 1);
        chk("z_fv_cnt", fv_cnt, 0);
        chk("z_td_cnt", td_cnt, 0);
        chk("z_post_busy", post_busy, 0);

        // Asynchronous reset mid-feed at serial 50.
        step();
        start = 1'b1; num_tiles = 4'd2;
        step();
        start = 1'b0;
        guard = 0;
        while (!(feed_valid && addr_serial_num == 7'd50) && guard < 200) begin
            step();
            guard++;
        end
        chk("rr_reached_50", 32'(addr_serial_num), 50);
        #2 srstn = 1'b0;
        #1;
        chk("rr_addr", 32'(addr_serial_num), 127);
        chk("rr_busy", 32'(busy), 0);
        chk("rr_fv", 32'(feed_valid), 0);
        step(); step();
        srstn = 1'b1;
        bad_pulses = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done || tile_done || busy || feed_valid) bad_pulses++;
        end
        chk("rr_no_activity", bad_pulses, 0);
        chk("rr_final_addr", 32'(addr_serial_num), 127);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
